// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: widths, key-schedule FSM states, Rcon and S-box.
package aes_pkg;

   localparam int KW  = 128;  // key / round-key width
   localparam int NRK = 11;   // stored round keys, index 0 is the cipher key
   localparam int RIW = 4;    // width of round counter and round-key index

   // Last expansion round; the edge in this round writes round key 10
   localparam logic [RIW-1:0] LAST_ROUND = 4'd9;

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      READY
   } state_e;

   // Round constants for rounds 0..9 (byte 0 of the word)
   localparam logic [7:0] RCON [0:9] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Forward S-box, entry 0 in the most significant byte
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry x sits at bit offset 8*(255-x), and 255-x equals ~x for a byte
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/keyexpand.sv
// One AES-128 key-expansion step: round key r -> round key r+1 (combinational).
module keyexpand
   import aes_pkg::*;
(
   input  logic [KW-1:0]  ikey_i,
   input  logic [RIW-1:0] round_i,
   output logic [KW-1:0]  okey_o
);

   logic [31:0] w [4];
   logic [31:0] n [4];
   logic [31:0] t;
   logic [7:0]  rc;

   // Split the key into words; byte 0 of each word is in its low bits
   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_word
      assign w[gi] = ikey_i[32*gi +: 32];
   end

   // RotWord + SubWord + Rcon applied to the last word of the previous key
   always_comb begin
      rc = 8'h00;
      if (round_i <= LAST_ROUND) begin
         rc = RCON[round_i];
      end
      t = {sbox(w[3][7:0]), sbox(w[3][31:24]), sbox(w[3][23:16]),
           sbox(w[3][15:8]) ^ rc};
   end

   // Word chain: each new word folds in the one before it
   assign n[0] = w[0] ^ t;
   for (gi = 1; gi < 4; gi++) begin : g_chain
      assign n[gi] = w[gi] ^ n[gi-1];
   end

   assign okey_o = {n[3], n[2], n[1], n[0]};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: expands a loaded key one round per clock
// into an 11-entry round-key file and serves indexed reads to the cipher core.
module aes_key_sched_ctrl
   import aes_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           key_in_valid,
   input  logic [KW-1:0]  key_in,
   output logic           key_in_ready,
   input  logic           key_clear,
   output logic           busy,
   output logic           keys_ready,
   input  logic           rk_req,
   input  logic [RIW-1:0] rk_idx,
   output logic           rk_valid,
   output logic           rk_err,
   output logic [KW-1:0]  rk_data
);

   state_e         state_q, state_d;
   logic [RIW-1:0] round_q, round_d;
   logic [KW-1:0]  rk_q [NRK];
   logic [KW-1:0]  kx_key;
   logic           load_acc;

   logic           req_q;
   logic [RIW-1:0] idx_q;
   logic           rk_valid_q, rk_err_q;
   logic [KW-1:0]  rk_data_q;

   assign key_in_ready = (state_q != EXPAND);
   assign busy         = (state_q == EXPAND);
   assign keys_ready   = (state_q == READY);
   assign load_acc     = key_in_valid && key_in_ready && !key_clear;

   assign rk_valid = rk_valid_q;
   assign rk_err   = rk_err_q;
   assign rk_data  = rk_data_q;

   keyexpand u_keyexpand (
      .ikey_i  (rk_q[round_q]),
      .round_i (round_q),
      .okey_o  (kx_key)
   );

   // Next state and round counter; zeroize beats load, load beats expansion
   always_comb begin
      state_d = state_q;
      round_d = round_q;
      if (key_clear) begin
         state_d = IDLE;
         round_d = '0;
      end else if (load_acc) begin
         state_d = EXPAND;
         round_d = '0;
      end else if (state_q == EXPAND) begin
         if (round_q == LAST_ROUND) begin
            state_d = READY;
            round_d = '0;
         end else begin
            round_d = round_q + 1'b1;
         end
      end
   end

   // State and round counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
      end
   end

   // Round-key file: key load fills entry 0, each expansion round fills the next
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NRK; i++) rk_q[i] <= '0;
      end else if (key_clear) begin
         for (int i = 0; i < NRK; i++) rk_q[i] <= '0;
      end else begin
         if (load_acc) begin
            rk_q[0] <= key_in;
         end
         if (state_q == EXPAND) begin
            rk_q[RIW'(round_q + 1'b1)] <= kx_key;
         end
      end
   end

   // Read port: capture the request, answer one edge later against the
   // state that the capturing edge produced
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q      <= 1'b0;
         idx_q      <= '0;
         rk_valid_q <= 1'b0;
         rk_err_q   <= 1'b0;
         rk_data_q  <= '0;
      end else begin
         req_q      <= rk_req;
         idx_q      <= rk_idx;
         rk_valid_q <= req_q;
         rk_err_q   <= 1'b0;
         if (key_clear) begin
            rk_err_q  <= req_q;
            rk_data_q <= '0;
         end else if (req_q) begin
            if (keys_ready && (idx_q <= RIW'(NRK - 1))) begin
               rk_data_q <= rk_q[idx_q];
            end else begin
               rk_err_q  <= 1'b1;
               rk_data_q <= '0;
            end
         end
      end
   end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Sequences the combinational `keyexpand` round-key datapath over AES-128 rounds 0..9, one round per clock. Stores all 11 round keys, numbered 0..10, in an internal register file. Serves the encrypt/decrypt round engine through an indexed read port with a valid handshake. Sits between the key-load interface and the cipher core, so the cipher never waits on combinational key expansion.

Parameters:
NRK, 11, number of stored round keys (round key 0 is the cipher key); fixed for AES-128, not intended to be overridden
KW, 128, key width in bits

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
key_in_valid  input  1  cipher key offered
key_in  input  128  cipher key; byte i at bits [8i+7:8i], byte 0 = first FIPS-197 key byte
key_in_ready  output  1  key load accepted when key_in_valid & key_in_ready
key_clear  input  1  zeroize request
busy  output  1  expansion in progress
keys_ready  output  1  all 11 round keys valid
rk_req  input  1  round-key read request
rk_idx  input  4  round-key index, 0..10
rk_valid  output  1  read response strobe
rk_err  output  1  qualifies rk_valid; request was rejected
rk_data  output  128  round key, same byte order as key_in

Behaviour:
- Reset (async): state IDLE; round counter 0; all register-file entries 0; key_in_ready=1; busy=0; keys_ready=0; rk_valid=0; rk_err=0; rk_data=0.
- States: IDLE, EXPAND, READY. key_in_ready=1 in IDLE and READY, 0 in EXPAND.
- Load: on an accepted edge E0, write rk[0]=key_in, set round=0 and go to EXPAND. keys_ready drops at E0.
- EXPAND: each edge writes rk[round+1] = keyexpand(rk[round], round) and increments round. The edge that writes rk[10] (E10, when round=9) moves the state to READY, sets keys_ready=1 and clears busy. busy=1 throughout EXPAND.
- Latency: keys_ready is high 10 cycles after the accepting edge.
- Single keyexpand instance. Its ikey input is muxed from rk[round]; its round input is the counter, 0..9 only.
- key_in_valid during EXPAND: not accepted (key_in_ready=0); the producer holds the key.
- Load in READY: restarts expansion and overwrites rk[0..10].
- key_clear: synchronous, any state, highest priority. Same cycle effect: all rk entries zeroed, state IDLE, keys_ready=0. A simultaneous key_in_valid is ignored.
- Read port: rk_req sampled at edge N produces a response at edge N+1 (1-cycle latency).
  - Response is rk_valid=1 for one cycle; back-to-back requests allowed, one response per request.
  - When keys_ready=1 and rk_idx<=10: rk_data=rk[rk_idx], rk_err=0.
  - When keys_ready=0 or rk_idx>10: rk_err=1 and rk_data=0.
  - A request in the same cycle as a load-accept or key_clear edge is evaluated against the post-edge state, so it gets rk_err=1.
- rk_data holds its last value when rk_valid=0. rk_data is zeroed on key_clear.
- Reset asserted mid-EXPAND: immediate return to reset values; no partial keys remain.

Decomposition:
- Shared package aes_pkg: KW, NRK, the round-index width (4), and the state enum {IDLE, EXPAND, READY}. Move the Rcon table into aes_pkg as a constant array so keyexpand and future blocks share one copy.
- Sub-module: reuse the existing keyexpand, instantiated once. No new sub-module is needed.

Test Plan:
- FIPS-197 A.1 load: key_in=128'h3c4fcf098815f7aba6d2ae2816157e2b. Required: keys_ready rises 10 cycles after accept; rk_idx=1 returns 128'h05766c2a3939a323b12c548817fefaa0; rk_idx=10 returns 128'ha60c63b6c80c3fe18925eec9a8f914d0; rk_idx=0 returns key_in.
- Read during EXPAND (cycle 5 after accept) with rk_idx=3 -> rk_valid=1, rk_err=1, rk_data=0. Read with rk_idx=11 in READY -> rk_err=1.
- key_in_valid held during EXPAND with a second key -> key_in_ready=0 until READY. Then accepted; rk[10] matches the second key's expansion.
- key_clear at cycle 4 of EXPAND with key_in_valid=1 -> IDLE; keys_ready=0; key not loaded; subsequent reads of any index give rk_err=1, rk_data=0.
- rst_n pulsed low mid-EXPAND -> outputs return to reset values asynchronously. A reload of the A.1 key then reproduces the round-10 key above.
- Back-to-back reads of rk_idx 10,9,...,0 on consecutive cycles (decrypt order) -> 11 consecutive rk_valid pulses with correct keys, rk_err=0.
